demux_stream_1xn: RTL and testbench

- Registered 1-to-N stream demultiplexer with valid/ready handshakes; the parametrised successor of the team's 1x2 combinational demux.
- Routes each accepted input word to one selected output channel, or to all channels in broadcast mode.
- Each channel has a one-entry output register, giving full throughput per channel.
- Sits between a single producer and N independent consumers; out-of-range selects are dropped and counted.

---
 rtl/demux_stream_1xn.sv | 105 ++++++++++
 tb/tb_demux_stream_1xn.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N valid/ready stream demultiplexer with optional broadcast.
// Each channel owns a one-entry output slot; out-of-range selects are dropped and counted.

module demux_stream_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A load wins over a drain, so a full slot refills without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

module demux_stream_1xn #(
    parameter int WIDTH    = 8,
    parameter int N        = 4,
    parameter int SEL_W    = 2,
    parameter int BCAST_EN = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [CNT_W-1:0]   drop_cnt
);
    localparam int NS = 1 << SEL_W;

    logic [N-1:0]     w_can_acc;
    logic [NS-1:0]    w_can_ext;
    logic [N-1:0]     w_load;
    logic             w_bcast;
    logic             w_sel_ok;
    logic             w_xfer;
    logic             w_drop;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_can_acc = ~out_valid | out_ready;
    // Zero-extended so any select value indexes safely; out-of-range entries are never used.
    assign w_can_ext = NS'(w_can_acc);
    assign w_bcast   = (BCAST_EN != 0) && in_bcast;
    assign w_sel_ok  = ({1'b0, in_sel} < (SEL_W+1)'(N));

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (w_bcast)       in_ready = &w_can_acc;
            else if (w_sel_ok) in_ready = w_can_ext[in_sel];
            else               in_ready = 1'b1;
        end
    end

    assign w_xfer = in_valid && in_ready;
    assign w_drop = w_xfer && !w_bcast && !w_sel_ok;

    for (genvar gi = 0; gi < N; gi++) begin : g_load
        assign w_load[gi] = w_xfer && (w_bcast || (w_sel_ok && in_sel == SEL_W'(gi)));
    end

    demux_stream_slot #(.WIDTH(WIDTH)) u_slot [N-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_ready (out_ready),
        .i_data  ({N{in_data}}),
        .o_valid (out_valid),
        .o_data  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_drop_cnt <= '0;
        else if (w_drop && !(&r_drop_cnt))
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end

    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: per-channel FIFO scoreboard on a 4-channel instance,
// plus two 3-channel instances for out-of-range drop counting and saturation.
module tb_demux_stream_1xn;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_bcast = 1'b0, in_valid = 1'b0, in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid, out_ready = '0;
    logic [15:0] drop_cnt;

    logic [7:0]  d3_data = '0;
    logic [1:0]  d3_sel = '0;
    logic        d3_bcast = 1'b0, d3_valid = 1'b0, a_rdy, b_rdy;
    logic [2:0]  d3_ordy = 3'b111, a_ovld, b_ovld;
    logic [23:0] a_odata, b_odata;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    demux_stream_1xn u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .drop_cnt(drop_cnt));

    demux_stream_1xn #(.N(3), .SEL_W(2), .CNT_W(16)) u_n3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_sel(d3_sel), .in_bcast(d3_bcast),
        .in_valid(d3_valid), .in_ready(a_rdy), .out_data(a_odata), .out_valid(a_ovld),
        .out_ready(d3_ordy), .drop_cnt(a_cnt));

    demux_stream_1xn #(.N(3), .SEL_W(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_sel(d3_sel), .in_bcast(d3_bcast),
        .in_valid(d3_valid), .in_ready(b_rdy), .out_data(b_odata), .out_valid(b_ovld),
        .out_ready(d3_ordy), .drop_cnt(b_cnt));

    int n_chk = 0;
    int n_bad = 0;
    logic [7:0] q [4][$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: slot i is full exactly when q[i] is non-empty.
    task automatic sb_cycle();
        logic erdy;
        erdy = 1'b1;
        if (in_bcast) begin
            for (int i = 0; i < 4; i++)
                if (q[i].size() != 0 && !out_ready[i]) erdy = 1'b0;
        end else begin
            erdy = (q[in_sel].size() == 0) || out_ready[in_sel];
        end
        chk("in_ready", 64'(in_ready), 64'(erdy));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(q[i].size() != 0));
            if (q[i].size() != 0)
                chk($sformatf("out_data[%0d]", i), 64'(out_data[i*8 +: 8]), 64'(q[i][0]));
        end
        for (int i = 0; i < 4; i++)
            if (q[i].size() != 0 && out_ready[i]) void'(q[i].pop_front());
        if (in_valid && erdy) begin
            if (in_bcast) for (int i = 0; i < 4; i++) q[i].push_back(in_data);
            else q[in_sel].push_back(in_data);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] d);
        in_valid = 1'b1; in_bcast = 1'b0; in_sel = sel; in_data = d;
        step();
    endtask

    initial begin
        in_valid = 1'b1;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;

        // unicast routing, all consumers ready
        out_ready = 4'b1111;
        send(2'd0, 8'h11); send(2'd1, 8'h22); send(2'd2, 8'h33); send(2'd3, 8'h44);
        in_valid = 1'b0; step(); step();

        // backpressure on channel 1
        out_ready = 4'b1101;
        send(2'd1, 8'h5A);
        send(2'd1, 8'h6B);
        send(2'd0, 8'h7C);
        send(2'd1, 8'h6B);
        chk("bp_hold_data", 64'(out_data[15:8]), 64'h5A);
        out_ready = 4'b1111;
        send(2'd1, 8'h6B);
        chk("bp_refill_data", 64'(out_data[15:8]), 64'h6B);
        chk("bp_refill_vld", 64'(out_valid[1]), 64'd1);
        in_valid = 1'b0; step(); step();

        // broadcast: all-or-nothing
        out_ready = 4'b1011;
        send(2'd2, 8'h99);
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'hC3;
        step();
        chk("bc_stall_rdy", 64'(in_ready), 64'd0);
        chk("bc_stall_vld", 64'(out_valid), 64'b0100);
        out_ready = 4'b1111;
        step();
        chk("bc_data", 64'(out_data), 64'hC3C3C3C3);
        chk("bc_vld", 64'(out_valid), 64'hF);
        in_valid = 1'b0; in_bcast = 1'b0;
        step(); step();

        // out-of-range drops on N=3
        for (int k = 0; k < 5; k++) begin
            d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 8'(k);
            @(negedge clk);
            chk("drop_rdy", 64'(a_rdy), 64'd1);
            chk("drop_rdy_sat", 64'(b_rdy), 64'd1);
            chk("drop_vld", 64'(a_ovld), 64'd0);
            @(posedge clk); #1;
        end
        d3_valid = 1'b0; #1;
        chk("drop_cnt5", 64'(a_cnt), 64'd5);
        chk("drop_sat5", 64'(b_cnt), 64'd3);
        d3_valid = 1'b1;
        @(posedge clk); #1;
        d3_sel = 2'd2; d3_data = 8'h3C;
        @(posedge clk); #1;
        d3_valid = 1'b0;
        chk("drop_cnt6", 64'(a_cnt), 64'd6);
        chk("drop_sat6", 64'(b_cnt), 64'd3);
        chk("n3_vld", 64'(a_ovld), 64'b100);
        chk("n3_data", 64'(a_odata[23:16]), 64'h3C);

        // asynchronous reset mid-traffic
        out_ready = 4'b1011;
        send(2'd2, 8'hA5);
        chk("pre_rst_data", 64'(out_data[23:16]), 64'hA5);
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h05;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_rdy", 64'(in_ready), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_n3_cnt", 64'(a_cnt), 64'd0);
        chk("arst_n3_vld", 64'(a_ovld), 64'd0);
        for (int i = 0; i < 4; i++) q[i].delete();
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // random stress
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_bcast  = ($urandom_range(7) == 0);
            in_sel    = 2'($urandom_range(3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            step();
        end
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b1111;
        step(); step(); step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("drain_q%0d", i), 64'(q[i].size()), 64'd0);
        chk("drain_vld", 64'(out_valid), 64'd0);
        chk("n4_drop_cnt", 64'(drop_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
